// File: rtl/aes_round_key_store_128.sv
// Round-key store between AES-128 key expansion and the iterative round core.
// Captures the NR+1 expanded keys once and replays them forward (encrypt) or reverse (decrypt).
module aes_round_key_store_128 #(
   parameter int unsigned NR = 10,
   parameter int unsigned KW = 128
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load_start,
   input  logic          kx_rdy,
   input  logic [KW-1:0] kx_subkey,
   input  logic          rd_start,
   input  logic          rd_decrypt,
   input  logic          rd_stall,
   output logic [KW-1:0] round_key,
   output logic [3:0]    round_idx,
   output logic          rd_valid,
   output logic          rd_last,
   output logic          keys_valid,
   output logic          load_err
);

   localparam int unsigned   IW       = 4;
   localparam logic [IW-1:0] LAST_IDX = IW'(NR);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOADING,
      S_READY,
      S_READ
   } state_e;

   state_e        state_q;
   logic [IW-1:0] wp_q;
   logic [IW-1:0] rp_q;
   logic          dec_q;
   logic [KW-1:0] mem_q [NR+1];
   logic [KW-1:0] round_key_q;
   logic [IW-1:0] round_idx_q;
   logic          rd_valid_q;
   logic          rd_last_q;
   logic          keys_valid_q;
   logic          load_err_q;

   // rp_q always names the next key to issue; a replay start issues its first key directly.
   logic          issue_dec;
   logic [IW-1:0] issue_idx;
   logic          issue_term;
   logic [IW-1:0] issue_next;

   always_comb begin
      issue_dec  = (state_q == S_READ) ? dec_q : rd_decrypt;
      issue_idx  = (state_q == S_READ) ? rp_q  : (rd_decrypt ? LAST_IDX : IW'(0));
      issue_term = issue_dec ? (issue_idx == IW'(0)) : (issue_idx == LAST_IDX);
      issue_next = issue_idx;
      if (!issue_term) begin
         issue_next = issue_dec ? (issue_idx - IW'(1)) : (issue_idx + IW'(1));
      end
   end

   // Control FSM, register file writes and registered replay outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         wp_q         <= '0;
         rp_q         <= '0;
         dec_q        <= 1'b0;
         round_key_q  <= '0;
         round_idx_q  <= '0;
         rd_valid_q   <= 1'b0;
         rd_last_q    <= 1'b0;
         keys_valid_q <= 1'b0;
         load_err_q   <= 1'b0;
      end else begin
         load_err_q <= 1'b0;
         if (load_start) begin
            // A new load always wins and kills any replay of the old key set.
            mem_q[0]     <= kx_subkey;
            wp_q         <= IW'(1);
            keys_valid_q <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_last_q    <= 1'b0;
            state_q      <= S_LOADING;
         end else begin
            case (state_q)
               S_IDLE, S_READY: begin
                  if (rd_start) begin
                     if (keys_valid_q) begin
                        dec_q       <= rd_decrypt;
                        round_key_q <= mem_q[issue_idx];
                        round_idx_q <= issue_idx;
                        rd_valid_q  <= 1'b1;
                        rd_last_q   <= issue_term;
                        rp_q        <= issue_next;
                        state_q     <= S_READ;
                     end else begin
                        load_err_q <= 1'b1;
                     end
                  end
               end
               S_LOADING: begin
                  if (rd_start) begin
                     load_err_q <= 1'b1;
                  end
                  if (kx_rdy) begin
                     mem_q[wp_q] <= kx_subkey;
                     wp_q        <= wp_q + IW'(1);
                     if (wp_q == LAST_IDX) begin
                        keys_valid_q <= 1'b1;
                        state_q      <= S_READY;
                     end
                  end else begin
                     load_err_q <= 1'b1;
                     state_q    <= S_IDLE;
                  end
               end
               S_READ: begin
                  if (!rd_stall) begin
                     if (rd_last_q) begin
                        rd_valid_q <= 1'b0;
                        rd_last_q  <= 1'b0;
                        state_q    <= S_READY;
                     end else begin
                        round_key_q <= mem_q[issue_idx];
                        round_idx_q <= issue_idx;
                        rd_valid_q  <= 1'b1;
                        rd_last_q   <= issue_term;
                        rp_q        <= issue_next;
                     end
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign round_key  = round_key_q;
   assign round_idx  = round_idx_q;
   assign rd_valid   = rd_valid_q;
   assign rd_last    = rd_last_q;
   assign keys_valid = keys_valid_q;
   assign load_err   = load_err_q;

endmodule

// File: tb/tb_aes_round_key_store_128.sv
// Bench for aes_round_key_store_128: directed loads/replays, replay keys checked by a queue-based monitor.
module tb_aes_round_key_store_128;

   localparam int unsigned NR = 10;
   localparam int unsigned KW = 128;

   // AES-128 key schedule for key 000102030405060708090a0b0c0d0e0f.
   localparam logic [KW-1:0] KEY_A [0:NR] = '{
      128'h000102030405060708090a0b0c0d0e0f,
      128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
      128'hb692cf0b643dbdf1be9bc5006830b3fe,
      128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
      128'h47f7f7bc95353e03f96c32bcfd058dfd,
      128'h3caaa3e8a99f9deb50f3af57adf622aa,
      128'h5e390f7df7a69296a7553dc10aa31f6b,
      128'h14f9701ae35fe28c440adf4d4ea9c026,
      128'h47438735a41c65b9e016baf4aebf7ad2,
      128'h549932d1f08557681093ed9cbe2c974e,
      128'h13111d7fe3944a17f307a78b4d2b30c5
   };

   logic          clk = 1'b0;
   logic          reset;
   logic          load_start;
   logic          kx_rdy;
   logic [KW-1:0] kx_subkey;
   logic          rd_start;
   logic          rd_decrypt;
   logic          rd_stall;
   logic [KW-1:0] round_key;
   logic [3:0]    round_idx;
   logic          rd_valid;
   logic          rd_last;
   logic          keys_valid;
   logic          load_err;

   typedef struct packed {
      logic [KW-1:0] key;
      logic [3:0]    idx;
      logic          last;
   } exp_t;

   exp_t exp_q [$];
   int   checks = 0;
   int   errors = 0;

   aes_round_key_store_128 #(.NR(NR), .KW(KW)) dut (
      .clk        (clk),
      .reset      (reset),
      .load_start (load_start),
      .kx_rdy     (kx_rdy),
      .kx_subkey  (kx_subkey),
      .rd_start   (rd_start),
      .rd_decrypt (rd_decrypt),
      .rd_stall   (rd_stall),
      .round_key  (round_key),
      .round_idx  (round_idx),
      .rd_valid   (rd_valid),
      .rd_last    (rd_last),
      .keys_valid (keys_valid),
      .load_err   (load_err)
   );

   always #5 clk = ~clk;

   function automatic logic [KW-1:0] key_of(input int sel, input int i);
      if (sel == 0) return KEY_A[4'(i)];
      return {4{32'hC0DE_0000 + 32'(i)}};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_bit(input string name, input logic act, input logic req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %b, required %b", name, act, req);
      end
   endtask

   task automatic check_key(input string name, input logic [KW-1:0] act, input logic [KW-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   // Expected replay stream, one entry per rd_valid cycle (stalled cycles repeat the key).
   task automatic push_seq(input int sel, input logic dec, input int stall_at, input int stall_n,
                           input int n_keys);
      exp_t e;
      for (int k = 0; k < n_keys; k++) begin
         int idx;
         idx    = dec ? (int'(NR) - k) : k;
         e.key  = key_of(sel, idx);
         e.idx  = 4'(idx);
         e.last = dec ? (idx == 0) : (idx == int'(NR));
         exp_q.push_back(e);
         if (idx == stall_at) begin
            for (int s = 0; s < stall_n; s++) exp_q.push_back(e);
         end
      end
   endtask

   task automatic load_begin(input int sel);
      load_start = 1'b1;
      kx_rdy     = 1'b0;
      kx_subkey  = key_of(sel, 0);
      tick();
      load_start = 1'b0;
   endtask

   task automatic load_rounds(input int sel, input int n);
      for (int i = 1; i <= n; i++) begin
         kx_rdy    = 1'b1;
         kx_subkey = key_of(sel, i);
         if (i == int'(NR)) check_bit("keys_valid_before_last", keys_valid, 1'b0);
         tick();
      end
      kx_rdy    = 1'b0;
      kx_subkey = '0;
   endtask

   task automatic start_replay(input logic dec);
      rd_start   = 1'b1;
      rd_decrypt = dec;
      tick();
      rd_start   = 1'b0;
   endtask

   task automatic check_drained(input string name);
      check_bit(name, exp_q.size() == 0, 1'b1);
      check_bit({name, "_valid_low"}, rd_valid, 1'b0);
   endtask

   // Monitor: every valid cycle must match the head of the expected queue.
   always @(negedge clk) begin
      exp_t e;
      if (rd_valid === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL replay_extra: got idx %0d key %h, required no valid key", round_idx, round_key);
         end else begin
            e = exp_q.pop_front();
            if (round_key !== e.key || round_idx !== e.idx || rd_last !== e.last) begin
               errors++;
               $display("FAIL replay_key: got idx %0d last %b key %h, required idx %0d last %b key %h",
                        round_idx, rd_last, round_key, e.idx, e.last, e.key);
            end
         end
      end
   end

   initial begin
      #100000;
      errors++;
      $display("FAIL watchdog: got timeout, required completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      reset      = 1'b1;
      load_start = 1'b0;
      kx_rdy     = 1'b0;
      kx_subkey  = '0;
      rd_start   = 1'b0;
      rd_decrypt = 1'b0;
      rd_stall   = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      check_bit("reset_rd_valid", rd_valid, 1'b0);
      check_bit("reset_rd_last", rd_last, 1'b0);
      check_bit("reset_keys_valid", keys_valid, 1'b0);
      check_bit("reset_load_err", load_err, 1'b0);
      check_key("reset_round_key", round_key, '0);
      check_key("reset_round_idx", KW'(round_idx), '0);

      // Replay request with no keys stored
      start_replay(1'b0);
      check_bit("empty_rd_err", load_err, 1'b1);
      check_bit("empty_rd_no_valid", rd_valid, 1'b0);
      tick();
      check_bit("empty_rd_err_pulse", load_err, 1'b0);

      // Full load of key A
      load_begin(0);
      load_rounds(0, NR);
      check_bit("load_keys_valid", keys_valid, 1'b1);
      check_bit("load_no_err", load_err, 1'b0);

      // Forward replay, then immediate back-to-back reverse replay
      push_seq(0, 1'b0, -1, 0, NR + 1);
      start_replay(1'b0);
      repeat (NR + 1) tick();
      check_drained("fwd_drain");
      check_key("fwd_key_hold", round_key, KEY_A[10]);
      push_seq(0, 1'b1, -1, 0, NR + 1);
      start_replay(1'b1);
      repeat (NR + 1) tick();
      check_drained("rev_drain");

      // Forward replay stalled three cycles at idx 4; rd_start during replay is ignored
      push_seq(0, 1'b0, 4, 3, NR + 1);
      start_replay(1'b0);
      repeat (4) tick();
      rd_stall   = 1'b1;
      rd_start   = 1'b1;
      rd_decrypt = 1'b1;
      tick();
      rd_start = 1'b0;
      check_bit("rd_start_in_read_no_err", load_err, 1'b0);
      repeat (2) tick();
      rd_stall = 1'b0;
      repeat (7) tick();
      check_drained("stall_drain");

      // load_start at idx 6 aborts the replay and loads key set B
      push_seq(0, 1'b0, -1, 0, 7);
      start_replay(1'b0);
      repeat (6) tick();
      load_begin(1);
      check_bit("interrupt_valid_drop", rd_valid, 1'b0);
      check_bit("interrupt_drain", exp_q.size() == 0, 1'b1);
      load_rounds(1, NR);
      check_bit("reload_keys_valid", keys_valid, 1'b1);
      push_seq(1, 1'b1, -1, 0, NR + 1);
      start_replay(1'b1);
      repeat (NR + 1) tick();
      check_drained("reload_rev_drain");

      // load_start with rd_start in READY: load wins silently, then abort after round 5
      load_start = 1'b1;
      rd_start   = 1'b1;
      rd_decrypt = 1'b0;
      kx_subkey  = key_of(0, 0);
      tick();
      load_start = 1'b0;
      rd_start   = 1'b0;
      check_bit("load_wins_no_err", load_err, 1'b0);
      check_bit("load_wins_no_valid", rd_valid, 1'b0);
      check_bit("load_wins_keys_cleared", keys_valid, 1'b0);
      load_rounds(0, 5);
      tick();
      check_bit("abort_err", load_err, 1'b1);
      check_bit("abort_keys_valid", keys_valid, 1'b0);
      tick();
      check_bit("abort_err_pulse", load_err, 1'b0);
      start_replay(1'b0);
      check_bit("abort_rd_err", load_err, 1'b1);
      check_bit("abort_rd_no_valid", rd_valid, 1'b0);
      tick();
      check_bit("abort_rd_still_idle", rd_valid, 1'b0);

      // Reset in the middle of a replay
      load_begin(0);
      load_rounds(0, NR);
      push_seq(0, 1'b0, -1, 0, 4);
      start_replay(1'b0);
      repeat (3) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_bit("rst_replay_valid", rd_valid, 1'b0);
      check_bit("rst_replay_last", rd_last, 1'b0);
      check_bit("rst_replay_keys_valid", keys_valid, 1'b0);
      check_key("rst_replay_round_key", round_key, '0);
      check_key("rst_replay_round_idx", KW'(round_idx), '0);
      check_bit("rst_replay_drain", exp_q.size() == 0, 1'b1);

      // Reset in the middle of a load; trailing kx_rdy must not complete it
      load_begin(0);
      load_rounds(0, 3);
      reset     = 1'b1;
      kx_rdy    = 1'b1;
      kx_subkey = key_of(0, 4);
      tick();
      reset = 1'b0;
      check_bit("rst_load_keys_valid", keys_valid, 1'b0);
      check_bit("rst_load_err", load_err, 1'b0);
      check_key("rst_load_round_key", round_key, '0);
      repeat (3) tick();
      kx_rdy = 1'b0;
      check_bit("rst_load_stays_empty", keys_valid, 1'b0);

      repeat (3) tick();
      check_bit("final_queue_empty", exp_q.size() == 0, 1'b1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/aes_round_key_store_128.md
Name: aes_round_key_store_128

Overview:
- Buffers the 11 round keys streamed out by the AES-128 key expansion stage, one key per cycle, in a register file.
- Replays them to the round datapath in one of two orders:
  - forward (round 0..10) for encryption;
  - reverse (round 10..0) for decryption.
- Sits directly downstream of key expansion and upstream of the iterative cipher round core.
- Lets one expansion serve repeated encrypt or decrypt blocks without re-expanding the key.

Parameters:
- NR, 10, number of cipher rounds; the store holds NR+1 round keys.
- KW, 128, round key width in bits.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- load_start  input  1  same signal that drives the key expansion start input; marks that round key 0 is on kx_subkey this cycle.
- kx_rdy  input  1  key expansion rdy; high while round keys 1..NR are presented on kx_subkey.
- kx_subkey  input  KW  round key from key expansion.
- rd_start  input  1  request replay of all NR+1 keys.
- rd_decrypt  input  1  sampled with rd_start: 0 = forward order, 1 = reverse order.
- rd_stall  input  1  hold the current output key and do not advance.
- round_key  output  KW  registered round key to the cipher core.
- round_idx  output  4  round index of round_key.
- rd_valid  output  1  round_key/round_idx are valid this cycle.
- rd_last  output  1  high with the final key of a replay (idx NR forward, idx 0 reverse).
- keys_valid  output  1  a complete set of NR+1 keys is stored.
- load_err  output  1  one-cycle pulse: load aborted, or a request was rejected.

Behaviour:
- Reset: all outputs 0; state IDLE; write pointer wp=0; read pointer rp=0; register-file contents don't-care (keys_valid=0 guards them).
- State IDLE or READY:
  - load_start=1: write kx_subkey to entry 0; wp<=1; keys_valid<=0; go to LOADING.
  - else rd_start=1 with keys_valid=1: go to READ; rp<=0 if rd_decrypt=0, else rp<=NR; latch direction.
  - rd_start with keys_valid=0: ignored; load_err pulses.
- State LOADING:
  - Each cycle with kx_rdy=1: write kx_subkey to entry wp; wp<=wp+1.
  - Writing entry NR: keys_valid<=1; go to READY.
  - kx_rdy=0 while wp<=NR: abort; load_err pulses; keys_valid stays 0; go to IDLE.
  - rd_start in LOADING: ignored; load_err pulses.
- State READ:
  - Each non-stalled cycle registers round_key<=entry[rp] and round_idx<=rp, with rd_valid=1 on the next cycle (1-cycle latency from rd_start to first key).
  - rp steps +1 forward or -1 reverse.
  - rd_last is asserted together with the terminal index.
  - After the terminal key has been issued, rd_valid<=0 next cycle and the block goes to READY.
- rd_stall:
  - rd_stall=1 while rd_valid=1: round_key, round_idx, rd_valid and rd_last hold; rp frozen.
  - rd_stall is ignored outside READ.
- load_start during READ: replay aborts immediately; rd_valid<=0; entry 0 is written; go to LOADING. Loading has priority and stale-key replay is not allowed.
- Simultaneous load_start and rd_start in IDLE/READY: load wins; rd_start dropped without load_err.
- Back-to-back replay: rd_start in READY on the cycle after rd_last has dropped starts a new replay. rd_start while in READ is ignored and gives no error.
- round_key between replays: holds its last value; consumers qualify on rd_valid.
- Reset mid-load or mid-replay returns to the reset state on the next edge.
- Widths: wp and rp are 4 bits; rp never leaves the range 0..NR.

Test Plan:
- Key 000102030405060708090a0b0c0d0e0f: drive load_start with key expansion over 11 cycles -> keys_valid=1 one cycle after round 10 is written; entry 10 = 13111d7fe3944a17f307a78b4d2b30c5.
- After load, rd_start with rd_decrypt=0 -> rd_valid high for 11 consecutive cycles; round_idx 0..10; first key 000102...0f; rd_last only at idx 10.
- rd_start with rd_decrypt=1 -> round_idx 10..0; first key 13111d7f...; rd_last at idx 0.
- Stall: assert rd_stall for 3 cycles at idx 4 of a forward replay -> key at idx 4 held for 4 cycles; sequence resumes at 5; total 14 valid cycles.
- Load abort: deassert kx_rdy after round 5 -> load_err pulse; keys_valid=0; a following rd_start gives another load_err and rd_valid stays 0.
- Interrupt and reset:
  - load_start at idx 6 of a replay -> rd_valid drops next cycle and the new key loads.
  - reset asserted mid-load -> all outputs 0 next cycle.
